// File: rtl/uart_tx_ser.sv
// UART transmitter: start bit, eight data bits LSB first, STOP_BITS stop bits,
// each bit lasting OVERSAMPLE ENABLE ticks. A one-word holding register lets the
// next word be queued while the current frame is on the line, so frames can be
// sent back to back without an idle gap.
module uart_tx_ser #(
    parameter int OVERSAMPLE = 5,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       res,
    input  logic       ENABLE,
    input  logic       START,
    input  logic [7:0] word_transmitter,
    output logic       TX,
    output logic       LOAD_READY,
    output logic       BUSY,
    output logic       priznak_end_transmitter
);

    localparam int             TW        = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0]  TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {IDLE, START_BIT, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    hold_q, hold_d;
    logic [7:0]    shift_q, shift_d;
    logic          ready_q, ready_d;
    logic          tx_q, tx_d;
    logic          end_q, end_d;

    logic bit_end;
    logic last_stop;
    logic load_acc;
    logic xfer;

    // bit_cnt doubles as the stop-bit counter while in STOP
    assign bit_end   = ENABLE && (tick_q == TICK_LAST);
    assign last_stop = bit_end && (bit_q == STOP_LAST);
    assign load_acc  = START && ready_q;
    // Hold-to-shift transfer happens on the first tick in IDLE or on the final stop tick
    assign xfer      = !ready_q && (((state_q == IDLE) && ENABLE) ||
                                    ((state_q == STOP) && last_stop));

    // State register; reset aborts any frame in progress
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (xfer) state_d = START_BIT;
            START_BIT: if (bit_end) state_d = DATA;
            DATA:      if (bit_end && (bit_q == 3'd7)) state_d = STOP;
            STOP:      if (last_stop) state_d = xfer ? START_BIT : IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Output and datapath next values; nothing but the load path moves without ENABLE
    always_comb begin
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        end_d   = 1'b0;
        hold_d  = hold_q;
        ready_d = ready_q;

        if (ENABLE) begin
            tick_d = bit_end ? '0 : tick_q + TW'(1);
            case (state_q)
                IDLE: begin
                    tick_d = '0;
                    tx_d   = 1'b1;
                    if (xfer) begin
                        shift_d = hold_q;
                        tx_d    = 1'b0;
                    end
                end
                START_BIT: begin
                    if (bit_end) begin
                        bit_d = 3'd0;
                        tx_d  = shift_q[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_q == 3'd7) begin
                            bit_d = 3'd0;
                            tx_d  = 1'b1;
                        end else begin
                            bit_d   = bit_q + 3'd1;
                            shift_d = shift_q >> 1;
                            tx_d    = shift_q[1];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (last_stop) begin
                            end_d = 1'b1;
                            bit_d = 3'd0;
                            tx_d  = !xfer;
                            if (xfer) shift_d = hold_q;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end
                default: begin
                    tx_d = 1'b1;
                end
            endcase
        end

        // A fresh load wins over the transfer freeing the holding register
        if (xfer) ready_d = 1'b1;
        if (load_acc) begin
            hold_d  = word_transmitter;
            ready_d = 1'b0;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            tick_q  <= '0;
            bit_q   <= 3'd0;
            hold_q  <= 8'd0;
            shift_q <= 8'd0;
            ready_q <= 1'b1;
            tx_q    <= 1'b1;
            end_q   <= 1'b0;
        end else begin
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            hold_q  <= hold_d;
            shift_q <= shift_d;
            ready_q <= ready_d;
            tx_q    <= tx_d;
            end_q   <= end_d;
        end
    end

    assign TX                      = tx_q;
    assign LOAD_READY              = ready_q;
    assign BUSY                    = (state_q != IDLE) || !ready_q;
    assign priznak_end_transmitter = end_q;

endmodule

// File: tb/tb_uart_tx_ser.sv
// Directed bench for uart_tx_ser: ENABLE ticks every 4 clk, frames recorded tick
// by tick and compared against the expected start/data/stop bit pattern.
module tb_uart_tx_ser;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       ENABLE = 1'b0;
    logic       START = 1'b0;
    logic [7:0] word_transmitter = 8'h00;
    logic       TX;
    logic       LOAD_READY;
    logic       BUSY;
    logic       priznak_end_transmitter;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_ser #(.OVERSAMPLE(5), .STOP_BITS(1)) dut (
        .clk                     (clk),
        .res                     (res),
        .ENABLE                  (ENABLE),
        .START                   (START),
        .word_transmitter        (word_transmitter),
        .TX                      (TX),
        .LOAD_READY              (LOAD_READY),
        .BUSY                    (BUSY),
        .priznak_end_transmitter (priznak_end_transmitter)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clk with the given inputs; outputs are sampled 1 time unit after the edge
    task automatic cyc(input logic en, input logic st, input logic [7:0] w);
        ENABLE = en;
        START = st;
        word_transmitter = w;
        @(posedge clk);
        #1;
        ENABLE = 0;
        START = 0;
    endtask

    // One ENABLE tick: three quiet clks (first may carry a START) then the tick clk
    task automatic tick(input logic st, input logic [7:0] w, output int ends);
        ends = 0;
        cyc(1'b0, st, w);
        ends += int'(priznak_end_transmitter);
        cyc(1'b0, 1'b0, 8'h00);
        ends += int'(priznak_end_transmitter);
        cyc(1'b0, 1'b0, 8'h00);
        ends += int'(priznak_end_transmitter);
        cyc(1'b1, 1'b0, 8'h00);
        ends += int'(priznak_end_transmitter);
    endtask

    // Line level after each tick of a frame, tick 0 being the transfer tick
    function automatic logic [49:0] frame_bits(input logic [7:0] b);
        logic [49:0] v;
        for (int k = 0; k < 50; k++) begin
            if (k < 5)       v[k] = 1'b0;
            else if (k < 45) v[k] = b[(k - 5) / 5];
            else             v[k] = 1'b1;
        end
        return v;
    endfunction

    // Runs ticks 1..50 of a frame whose transfer tick has just happened
    task automatic frame(input logic [7:0] b, input int inj_k, input logic [7:0] inj_w,
                         input int frz_k, input string tag);
        logic [49:0] obs;
        logic [7:0]  dec;
        logic        tx0;
        int          e, ends_mid, busy_low, chg;
        obs = '0;
        ends_mid = 0;
        busy_low = 0;
        chg = 0;
        obs[0] = TX;
        for (int k = 1; k <= 50; k++) begin
            if (k == frz_k) begin
                tx0 = TX;
                repeat (100) begin
                    cyc(1'b0, 1'b0, 8'h00);
                    if (TX !== tx0) chg++;
                    ends_mid += int'(priznak_end_transmitter);
                end
                chk({tag, "_frozen_tx_changes"}, chg, 0);
            end
            tick(k == inj_k, inj_w, e);
            if (k < 50) begin
                obs[k] = TX;
                ends_mid += e;
                if (BUSY !== 1'b1) busy_low++;
            end else begin
                chk({tag, "_end_pulse_tick50"}, e, 1);
            end
        end
        chk({tag, "_tx_bits"}, obs, frame_bits(b));
        chk({tag, "_early_end_pulses"}, ends_mid, 0);
        chk({tag, "_busy_low_in_frame"}, busy_low, 0);
        for (int i = 0; i < 8; i++) dec[i] = obs[5 + 5 * i + 2];
        chk({tag, "_decoded_word"}, dec, b);
    endtask

    initial begin
        int e;
        int ends;
        int txlow;

        // Reset state
        #2 res = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx", TX, 1);
        chk("rst_load_ready", LOAD_READY, 1);
        chk("rst_busy", BUSY, 0);
        chk("rst_end", priznak_end_transmitter, 0);
        #2 res = 1'b1;

        // Single frame 0xA5
        cyc(1'b0, 1'b1, 8'hA5);
        chk("t1_lr_after_load", LOAD_READY, 0);
        chk("t1_busy_after_load", BUSY, 1);
        tick(1'b0, 8'h00, e);
        chk("t1_start_low", TX, 0);
        chk("t1_lr_after_xfer", LOAD_READY, 1);
        frame(8'hA5, -1, 8'h00, -1, "t1");
        chk("t1_idle_tx", TX, 1);
        chk("t1_idle_busy", BUSY, 0);

        // Back-to-back 0x3C, 0xC3 with an ignored 0xFF while the holding register is full
        cyc(1'b0, 1'b1, 8'h3C);
        tick(1'b0, 8'h00, e);
        chk("t2_lr_free", LOAD_READY, 1);
        cyc(1'b0, 1'b1, 8'hC3);
        chk("t2_hold_full", LOAD_READY, 0);
        frame(8'h3C, 20, 8'hFF, -1, "t2a");
        chk("t2_no_gap_start", TX, 0);
        chk("t3_ff_ignored_lr", LOAD_READY, 1);
        chk("t2_busy_between", BUSY, 1);
        frame(8'hC3, -1, 8'h00, -1, "t2b");
        chk("t3_idle_tx", TX, 1);
        chk("t3_idle_busy", BUSY, 0);
        ends = 0;
        txlow = 0;
        repeat (55) begin
            tick(1'b0, 8'h00, e);
            ends += e;
            if (TX !== 1'b1) txlow++;
        end
        chk("t3_no_third_frame_end", ends, 0);
        chk("t3_no_third_frame_tx", txlow, 0);

        // Reset at tick 23 of a 0x96 frame (data bit 3 = 0 on the line)
        cyc(1'b0, 1'b1, 8'h96);
        tick(1'b0, 8'h00, e);
        for (int k = 1; k <= 23; k++) tick(1'b0, 8'h00, e);
        chk("t4_pre_reset_tx", TX, 0);
        #2 res = 1'b0;
        #1;
        chk("t4_reset_tx", TX, 1);
        chk("t4_reset_lr", LOAD_READY, 1);
        chk("t4_reset_busy", BUSY, 0);
        ends = 0;
        txlow = 0;
        repeat (3) begin
            tick(1'b0, 8'h00, e);
            ends += e;
            if (TX !== 1'b1) txlow++;
        end
        chk("t4_no_end_in_reset", ends, 0);
        chk("t4_tx_high_in_reset", txlow, 0);
        #2 res = 1'b1;
        cyc(1'b0, 1'b1, 8'h81);
        tick(1'b0, 8'h00, e);
        frame(8'h81, -1, 8'h00, -1, "t4");
        chk("t4_idle_busy", BUSY, 0);

        // ENABLE stalled 100 clk mid-data, then decoded as 0x5A
        cyc(1'b0, 1'b1, 8'h5A);
        tick(1'b0, 8'h00, e);
        frame(8'h5A, -1, 8'h00, 17, "t5");
        chk("t5_idle_tx", TX, 1);
        chk("t5_idle_lr", LOAD_READY, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
